// File: rtl/uart_rx_fifo_if.sv
// Byte stream handshake between the UART receiver FIFO and its consumer.
// master: the FIFO side (presents head byte); slave: the consumer side.
interface uart_rx_fifo_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, mid-bit sampling) feeding a first-word-fall-through FIFO.
// Optional macro UART_RX_PARITY_EN switches framing to 8E1 (parity state,
// parity failure reported as frame_err and the byte discarded).
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 4167,
  parameter int DEPTH        = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx,
  uart_rx_fifo_if.master           bus,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     frame_err,
  output logic                     overrun,
  output logic [1:0]               err_sticky,
  input  logic                     err_clr
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic          rx_meta, rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          armed;   // line seen high since the last start/break
  logic          par_ok;
  logic          stop_ok;
  logic          push;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          valid, full, pop, wr;

  // Two-flop synchroniser; idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign par_ok = ~^{shreg, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  assign stop_ok = rxs & par_ok;
  assign push    = (state == STOP) && (cnt == CNT_LAST) && stop_ok;

  // Receiver FSM: start qualification, data shift, stop check, error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      armed     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rxs) armed <= 1'b1;
          else if (armed) begin
            state <= START;
            busy  <= 1'b1;
            armed <= 1'b0;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (!rxs) state <= DATA;
            else begin
              // Short low glitch: drop back quietly
              state <= IDLE;
              busy  <= 1'b0;
              armed <= 1'b1;
            end
          end else cnt <= cnt + 1'b1;
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == 3'd7) state <= PARITY;
`else
            if (bit_idx == 3'd7) state <= STOP;
`endif
          end else cnt <= cnt + 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            par_bit <= rxs;
            state   <= STOP;
          end else cnt <= cnt + 1'b1;
        end
`endif
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            // A low stop (break) must see the line rise before a new start
            armed <= rxs;
            if (!stop_ok) frame_err <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign valid        = (fifo_count != '0);
  assign full         = (fifo_count == ($clog2(DEPTH)+1)'(DEPTH));
  assign pop          = valid & bus.rx_ready;
  assign wr           = push & (~full | pop);
  assign bus.rx_valid = valid;
  assign bus.rx_data  = mem[rd_ptr];

  // FWFT FIFO storage, pointers, occupancy and overrun pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= push & full & ~pop;
      if (wr) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sticky error flags; a new pulse beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_sticky <= '0;
    else        err_sticky <= (err_clr ? 2'b00 : err_sticky) | {overrun, frame_err};
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Serial receiver for the user-project UART. Its input is mprj_io[5], driven by the bench UART transmitter (tbuart ser_tx). It deserialises 8N1 frames, using mid-bit sampling from a divided clock. Received bytes are buffered in a small first-word-fall-through FIFO, which the firmware-facing register logic drains over a valid/ready handshake.

Parameters:
CLKS_PER_BIT, 4167, clk cycles per bit; 40 MHz / 9600 baud; legal range is 4 or more.
DEPTH, 8, FIFO entries; must be a power of 2, at least 2.

Ports:
clk  input  1  system clock (40 MHz)
rst_n  input  1  asynchronous active-low reset
rx  input  1  serial line; idles high; asynchronous to clk
rx_data  output  8  FIFO head byte; valid while rx_valid=1
rx_valid  output  1  FIFO not empty
rx_ready  input  1  consumer pops the head when rx_valid&rx_ready
fifo_count  output  $clog2(DEPTH)+1  number of entries held
busy  output  1  receiver FSM not in IDLE
frame_err  output  1  1-cycle pulse: stop bit sampled 0
overrun  output  1  1-cycle pulse: byte dropped because FIFO full
err_sticky  output  2  {overrun, frame_err} latched; cleared by err_clr
err_clr  input  1  clears err_sticky; a same-cycle new error wins

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is asynchronous and active-low.
  - All outputs reset to 0; rx_data=8'h00.
  - The 2-FF rx synchroniser resets to 1.
  - FSM goes to IDLE; FIFO pointers and count go to 0.
- Reset asserted mid-frame aborts the frame; no partial byte is written.
- Synchroniser: 2 flops. The FSM sees only the synchronised rx (rxs).
- Bit counter: counts 0..CLKS_PER_BIT-1. The bit index counts 0..7.
- IDLE:
  - rxs==0 -> go to START, clear the counter.
  - busy=0 only in IDLE.
- START: at counter==CLKS_PER_BIT/2-1 (integer division), sample rxs.
  - rxs==0 -> go to DATA and clear the counter.
  - rxs==1 -> glitch; return to IDLE with no error.
- DATA:
  - At counter==CLKS_PER_BIT-1, sample rxs into the shift register, LSB first.
  - After bit 7 -> go to STOP (or PARITY if UART_RX_PARITY_EN).
- STOP: at counter==CLKS_PER_BIT-1 (mid stop bit), sample rxs and return to IDLE in the same edge. Next-frame start detection is therefore possible from the following cycle.
  - rxs==1 -> push the byte.
  - rxs==0 -> frame_err pulse; the byte is discarded.
- FIFO:
  - First-word fall-through: rx_data always shows mem[rd_ptr].
  - Latency: the push occurs on the stop-sample edge; rx_valid=1 and rx_data are updated on the next cycle.
  - Pop when rx_valid & rx_ready. rx_ready is ignored when empty.
  - Pointers are $clog2(DEPTH) bits wide and wrap naturally.
  - Push while full with no pop -> byte dropped, overrun pulse, contents unchanged.
  - Push and pop in the same cycle while full -> both succeed; count stays at DEPTH; no overrun.
  - Push and pop in the same cycle at count 1 -> count stays 1; the new byte becomes the head next cycle.
- Break condition (rx held low): a frame_err pulse occurs at stop. The FSM re-enters START only after rxs returns high and then falls again; IDLE requires a rising edge first.
- err_sticky bits are set on their pulses. err_clr clears them, but a same-cycle pulse keeps its bit set.

Optional Feature:
UART_RX_PARITY_EN.
- Defined: frames are 8E1. A PARITY state follows DATA and samples the bit at counter==CLKS_PER_BIT-1.
  - If XOR(data,parity) is not 0, the byte is discarded at stop and a frame_err pulse is issued. Parity error and bad stop give a single pulse.
- Undefined: 8N1 only; there is no PARITY state and no parity logic.

Test Plan:
1. CLKS_PER_BIT=16; send 8'hA5 8N1 with rx_ready=0 -> rx_valid rises 1 cycle after the stop sample; rx_data=8'hA5; fifo_count=1; busy=0; no error pulses.
2. Send 8'h00, 8'hFF, 8'h3C back to back, then hold rx_ready=1 -> pops in order 00, FF, 3C; count returns to 0; rx_valid=0.
3. DEPTH=8; send 9 bytes 0..8 with rx_ready=0 -> count=8; one overrun pulse on byte 8; err_sticky=2'b10. Drain -> 0..7. Then pulse err_clr -> err_sticky=0.
4. Send 8'h55 with the stop bit driven 0 -> frame_err pulse; count unchanged. Then a 4-cycle low glitch on idle rx -> busy returns 0 with no error and no push.
5. Assert rst_n=0 mid DATA bit 4, release, then send 8'h81 -> exactly one byte 8'h81 is received.
6. With UART_RX_PARITY_EN: send 8'h07 with parity 1 (correct even parity) -> accepted. Send 8'h07 with parity 0 -> frame_err and no push.
